l2_maxpool_stream: RTL and testbench

// Streaming 2x2/stride-2 signed max-pool between the layer-1 conv output and the layer-2 input memory.

---
 rtl/l2_maxpool_stream.sv | 147 ++++++++++++++
 tb/tb_l2_maxpool_stream.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_maxpool_stream.sv
// Streaming 2x2 / stride-2 signed max-pool between the layer-1 conv output and the layer-2 input memory.
// Pixels arrive in raster order (x, then y, then channel); pooled words leave with their coordinates.
`timescale 1ns/1ps

module l2_maxpool_stream #(
    parameter int DATA_SIZE   = 64,
    parameter int INPUT_DIM   = 26,
    parameter int NUM_CHANNEL = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_SIZE-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_SIZE-1:0] out_data,
    output logic [15:0]          out_x,
    output logic [15:0]          out_y,
    output logic [15:0]          out_ch,
    output logic                 frame_done
);

    localparam int          OUT_DIM = INPUT_DIM / 2;
    localparam int          IDX_W   = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam logic [15:0] XY_LAST = 16'(INPUT_DIM - 1);
    localparam logic [15:0] CH_LAST = 16'(NUM_CHANNEL - 1);

    generate
        if ((INPUT_DIM % 2) != 0) begin : g_bad_dim
            $error("l2_maxpool_stream: INPUT_DIM must be even");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                       state;
    logic [15:0]                  x;
    logic [15:0]                  y;
    logic [15:0]                  ch;
    logic signed [DATA_SIZE-1:0]  hold;
    logic signed [DATA_SIZE-1:0]  line_buf [OUT_DIM];
    logic                         accept;
    logic                         last_pixel;
    logic [IDX_W-1:0]             lb_idx;
    logic signed [DATA_SIZE-1:0]  pix;
    logic signed [DATA_SIZE-1:0]  pair_max;
    logic signed [DATA_SIZE-1:0]  window_max;

    function automatic logic signed [DATA_SIZE-1:0] smax(input logic signed [DATA_SIZE-1:0] a,
                                                         input logic signed [DATA_SIZE-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // A full output register that is not being drained this cycle stalls the input side.
    assign in_ready   = (state == RUN) && !(out_valid && !out_ready);
    assign accept     = in_valid && in_ready;
    assign last_pixel = (x == XY_LAST) && (y == XY_LAST) && (ch == CH_LAST);
    assign pix        = $signed(in_data);
    assign lb_idx     = x[IDX_W:1];
    assign pair_max   = smax(hold, pix);
    assign window_max = smax(line_buf[lb_idx], pair_max);

    // Even rows fold pixel pairs into the line buffer; odd rows combine with it on the odd column.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (!x[0]) begin
                hold <= pix;
            end else if (!y[0]) begin
                line_buf[lb_idx] <= pair_max;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            x          <= '0;
            y          <= '0;
            ch         <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_x      <= '0;
            out_y      <= '0;
            out_ch     <= '0;
        end else begin
            frame_done <= 1'b0;

            if (accept && x[0] && y[0]) begin
                out_valid <= 1'b1;
                out_data  <= window_max;
                out_x     <= {1'b0, x[15:1]};
                out_y     <= {1'b0, y[15:1]};
                out_ch    <= ch;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (accept) begin
                if (x == XY_LAST) begin
                    x <= '0;
                    if (y == XY_LAST) begin
                        y  <= '0;
                        ch <= (ch == CH_LAST) ? 16'd0 : ch + 16'd1;
                    end else begin
                        y <= y + 16'd1;
                    end
                end else begin
                    x <= x + 16'd1;
                end
            end

            // The frame only ends once the final pooled word has left the output register.
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (accept && last_pixel) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!out_valid) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2_maxpool_stream.sv
// Directed and model-based bench for l2_maxpool_stream: a 4x4x1 instance for table-driven windows
// and corner sequences, and a default-size instance for the full random frame and mid-frame reset.
`timescale 1ns/1ps

module tb_l2_maxpool_stream;

    localparam int DW     = 64;
    localparam int F_DIM  = 26;
    localparam int F_CH   = 16;
    localparam int F_OUT  = F_DIM / 2;
    localparam int F_PIX  = F_DIM * F_DIM * F_CH;
    localparam int F_OUTS = F_OUT * F_OUT * F_CH;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    logic          s_start = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b1;
    logic [DW-1:0] s_in_data = '0;
    logic          s_busy, s_in_ready, s_out_valid, s_frame_done;
    logic [DW-1:0] s_out_data;
    logic [15:0]   s_out_x, s_out_y, s_out_ch;

    logic          f_start = 1'b0, f_in_valid = 1'b0, f_out_ready = 1'b1;
    logic [DW-1:0] f_in_data = '0;
    logic          f_busy, f_in_ready, f_out_valid, f_frame_done;
    logic [DW-1:0] f_out_data;
    logic [15:0]   f_out_x, f_out_y, f_out_ch;

    l2_maxpool_stream #(.DATA_SIZE(DW), .INPUT_DIM(4), .NUM_CHANNEL(1)) u_small (
        .clk(clk), .reset(rst_n), .start(s_start), .busy(s_busy),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .out_x(s_out_x), .out_y(s_out_y), .out_ch(s_out_ch), .frame_done(s_frame_done)
    );

    l2_maxpool_stream #(.DATA_SIZE(DW), .INPUT_DIM(F_DIM), .NUM_CHANNEL(F_CH)) u_full (
        .clk(clk), .reset(rst_n), .start(f_start), .busy(f_busy),
        .in_valid(f_in_valid), .in_ready(f_in_ready), .in_data(f_in_data),
        .out_valid(f_out_valid), .out_ready(f_out_ready), .out_data(f_out_data),
        .out_x(f_out_x), .out_y(f_out_y), .out_ch(f_out_ch), .frame_done(f_frame_done)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [47:0]   xyc;
    } out_t;

    // One 2x2 window: a=(0,0) b=(1,0) c=(0,1) d=(1,1), mx = hand-computed signed max.
    typedef struct {
        logic signed [DW-1:0] a, b, c, d, mx;
    } win_t;

    win_t          tbl [12];
    out_t          s_got[$];
    out_t          f_got[$];
    out_t          so, fo;
    out_t          f_exp [F_OUTS];
    logic [DW-1:0] fpix [F_PIX];
    int            s_done_cnt = 0, f_done_cnt = 0, s_done_cyc = 0;
    int            total = 0, passed = 0;
    bit            f_stop = 1'b0;

    // Handshakes are sampled at negedge; inputs only change just after posedge.
    always @(negedge clk) begin
        if (s_out_valid && s_out_ready) begin
            so.data = s_out_data;
            so.xyc  = {s_out_x, s_out_y, s_out_ch};
            s_got.push_back(so);
        end
        if (f_out_valid && f_out_ready) begin
            fo.data = f_out_data;
            fo.xyc  = {f_out_x, f_out_y, f_out_ch};
            f_got.push_back(fo);
        end
        if (s_frame_done) begin
            s_done_cnt++;
            s_done_cyc = cyc;
        end
        if (f_frame_done) f_done_cnt++;
    end

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic timeoutFail(input string name);
        total++;
        $display("[TB] FAIL %s: timed out waiting", name);
    endtask

    function automatic logic [DW-1:0] pixOf(input int f, input int x, input int y);
        win_t w;
        int   sel;
        w   = tbl[f*4 + (y/2)*2 + x/2];
        sel = (y % 2) * 2 + (x % 2);
        case (sel)
            0:       return w.a;
            1:       return w.b;
            2:       return w.c;
            default: return w.d;
        endcase
    endfunction

    function automatic logic signed [DW-1:0] max2(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    task automatic applyStimulus(input bit full, input logic [DW-1:0] v, input bit gaps);
        int n = 0;
        if (full) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                f_in_valid = 1'b0;
                @(posedge clk); #1;
            end
            f_in_data = v; f_in_valid = 1'b1;
            @(negedge clk);
            while (!f_in_ready && n < 60) begin n++; @(negedge clk); end
            if (!f_in_ready) timeoutFail("full_in_ready");
            @(posedge clk); #1;
            f_in_valid = 1'b0;
        end else begin
            s_in_data = v; s_in_valid = 1'b1;
            @(negedge clk);
            while (!s_in_ready && n < 60) begin n++; @(negedge clk); end
            if (!s_in_ready) timeoutFail("small_in_ready");
            @(posedge clk); #1;
            s_in_valid = 1'b0;
        end
    endtask

    task automatic pulseStart(input bit full);
        @(posedge clk); #1;
        if (full) f_start = 1'b1; else s_start = 1'b1;
        @(posedge clk); #1;
        f_start = 1'b0; s_start = 1'b0;
    endtask

    task automatic waitDone(input bit full, input int base, input int limit);
        int n = 0;
        @(negedge clk);
        while (((full ? f_done_cnt : s_done_cnt) <= base) && n < limit) begin n++; @(negedge clk); end
        if ((full ? f_done_cnt : s_done_cnt) <= base) timeoutFail(full ? "full_frame_done" : "small_frame_done");
    endtask

    task automatic checkSmallFrame(input int f, input int base);
        checkOutput("small_out_count", 64'(s_got.size()), 64'd4);
        for (int j = 0; j < 4; j++) begin
            if (j < s_got.size()) begin
                checkOutput($sformatf("small_f%0d_w%0d_data", f, j), s_got[j].data, tbl[f*4 + j].mx);
                checkOutput($sformatf("small_f%0d_w%0d_xyc", f, j), 64'(s_got[j].xyc),
                            64'({16'(j % 2), 16'(j / 2), 16'd0}));
            end
        end
        repeat (3) @(negedge clk);
        checkOutput("small_done_pulses", 64'(s_done_cnt - base), 64'd1);
        checkOutput("small_idle_busy", 64'(s_busy), 64'd0);
    endtask

    // glitch_at >= 0 raises start alongside that pixel, while the block is already running.
    task automatic runSmallFrame(input int f, input int glitch_at, output int dur);
        int base, t0;
        s_got.delete();
        base = s_done_cnt;
        pulseStart(1'b0);
        t0 = cyc;
        for (int p = 0; p < 16; p++) begin
            if (p == glitch_at) s_start = 1'b1;
            applyStimulus(1'b0, pixOf(f, p % 4, p / 4), 1'b0);
            s_start = 1'b0;
        end
        waitDone(1'b0, base, 100);
        dur = s_done_cyc - t0;
        checkSmallFrame(f, base);
    endtask

    initial begin
        int base_dur, dur, base;

        tbl[0]  = '{0, 1, 4, 5, 5};
        tbl[1]  = '{2, 3, 6, 7, 7};
        tbl[2]  = '{8, 9, 12, 13, 13};
        tbl[3]  = '{10, 11, 14, 15, 15};
        tbl[4]  = '{-8, -3, -5, -9, -3};
        tbl[5]  = '{-1, -1, -1, -1, -1};
        tbl[6]  = '{64'sh8000_0000_0000_0000, 64'sh7FFF_FFFF_FFFF_FFFF, 0, -1, 64'sh7FFF_FFFF_FFFF_FFFF};
        tbl[7]  = '{100, -200, 100, 99, 100};
        tbl[8]  = '{7, 1, 2, 3, 7};
        tbl[9]  = '{1, 2, 3, -4, 3};
        tbl[10] = '{-5, -6, -7, -2, -2};
        tbl[11] = '{0, 0, 0, 0, 0};

        #3 rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rst_busy", 64'(s_busy), 64'd0);
        checkOutput("rst_in_ready", 64'(s_in_ready), 64'd0);
        checkOutput("rst_out_valid", 64'(s_out_valid), 64'd0);
        checkOutput("rst_out_data", s_out_data, 64'd0);
        checkOutput("rst_out_xyc", 64'({s_out_x, s_out_y, s_out_ch}), 64'd0);
        checkOutput("rst_frame_done", 64'(s_frame_done), 64'd0);
        checkOutput("rst_full_valid_busy", 64'({f_out_valid, f_busy}), 64'd0);
        rst_n = 1'b1;

        // Table frames: frame 0 is the 0..15 raster ramp, frames 1-2 cover signed and tie cases.
        for (int f = 0; f < 3; f++) begin
            runSmallFrame(f, -1, dur);
            if (f == 0) base_dur = dur;
        end

        // Hold the first pooled word for ten cycles with the consumer stalled.
        s_got.delete();
        base = s_done_cnt;
        s_out_ready = 1'b0;
        pulseStart(1'b0);
        fork
            begin
                for (int p = 0; p < 16; p++) applyStimulus(1'b0, pixOf(0, p % 4, p / 4), 1'b0);
            end
            begin
                int n = 0;
                @(negedge clk);
                while (!s_out_valid && n < 100) begin n++; @(negedge clk); end
                if (!s_out_valid) timeoutFail("bp_first_out");
                for (int i = 0; i < 10; i++) begin
                    checkOutput("bp_hold_data", s_out_data, 64'd5);
                    checkOutput("bp_hold_x", 64'(s_out_x), 64'd0);
                    checkOutput("bp_in_ready_low", 64'(s_in_ready), 64'd0);
                    @(negedge clk);
                end
                @(posedge clk); #1;
                s_out_ready = 1'b1;
            end
        join
        waitDone(1'b0, base, 100);
        checkSmallFrame(0, base);

        runSmallFrame(0, 5, dur);
        checkOutput("start_in_run_timing", 64'(dur), 64'(base_dur));

        // Mid-frame reset on the full-size block, right after pixel 99 produced a word.
        f_out_ready = 1'b1;
        pulseStart(1'b1);
        for (int p = 0; p < 100; p++) applyStimulus(1'b1, 64'(p * 3 - 50), 1'b0);
        checkOutput("rst_mid_pre_valid", 64'(f_out_valid), 64'd1);
        checkOutput("rst_mid_pre_xy", 64'({f_out_x, f_out_y}), 64'({16'd10, 16'd1}));
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_valid", 64'(f_out_valid), 64'd0);
        checkOutput("rst_mid_busy", 64'(f_busy), 64'd0);
        checkOutput("rst_mid_in_ready", 64'(f_in_ready), 64'd0);
        rst_n = 1'b1;

        // Fresh full frame with random data and random valid/ready, against the pooling model.
        for (int p = 0; p < F_PIX; p++) begin
            fpix[p] = {$urandom, $urandom};
            if (p > 0 && $urandom_range(0, 7) == 0) fpix[p] = fpix[p-1];
        end
        for (int c = 0; c < F_CH; c++)
            for (int oy = 0; oy < F_OUT; oy++)
                for (int ox = 0; ox < F_OUT; ox++) begin
                    int b;
                    b = c * F_DIM * F_DIM + 2 * oy * F_DIM + 2 * ox;
                    f_exp[(c * F_OUT + oy) * F_OUT + ox].data =
                        max2(max2(fpix[b], fpix[b+1]), max2(fpix[b+F_DIM], fpix[b+F_DIM+1]));
                    f_exp[(c * F_OUT + oy) * F_OUT + ox].xyc = {16'(ox), 16'(oy), 16'(c)};
                end
        f_got.delete();
        base = f_done_cnt;
        f_stop = 1'b0;
        pulseStart(1'b1);
        fork
            begin
                for (int p = 0; p < F_PIX; p++) applyStimulus(1'b1, fpix[p], 1'b1);
                waitDone(1'b1, base, 2000);
                f_stop = 1'b1;
            end
            begin
                while (!f_stop) begin
                    @(posedge clk); #1;
                    f_out_ready = ($urandom_range(0, 3) != 0);
                end
                f_out_ready = 1'b1;
            end
        join
        checkOutput("full_out_count", 64'(f_got.size()), 64'(F_OUTS));
        for (int k = 0; k < F_OUTS; k++) begin
            if (k < f_got.size()) begin
                checkOutput($sformatf("full_out%0d_data", k), f_got[k].data, f_exp[k].data);
                checkOutput($sformatf("full_out%0d_xyc", k), 64'(f_got[k].xyc), 64'(f_exp[k].xyc));
            end
        end
        repeat (3) @(negedge clk);
        checkOutput("full_done_pulses", 64'(f_done_cnt - base), 64'd1);
        checkOutput("full_idle_busy", 64'(f_busy), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
